// File: rtl/ram_arbiter_2p.sv
// Two-client round-robin arbiter/sequencer for a single 8x8 synchronous RAM.
// Issues one registered RAM command per grant; read data returns 3 cycles after gnt.
module ram_arbiter_2p #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_wr_enb,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rd_enb,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic              ptr;       // 1: B favoured on contention
  logic              any_gnt;
  logic              rd_go;
  req_t              sel;
  logic [STAGES:1]   vld_pipe;
  logic [STAGES:1]   id_pipe;   // 1: read belongs to B

  // Gated by rst so grants read 0 while reset is held.
  assign a_gnt   = rst & a_req & (~b_req | ~ptr);
  assign b_gnt   = rst & b_req & (~a_req |  ptr);
  assign any_gnt = a_gnt | b_gnt;

  always_comb begin
    sel = '{we: a_we, addr: a_addr, wdata: a_wdata};
    if (b_gnt) sel = '{we: b_we, addr: b_addr, wdata: b_wdata};
  end

  assign rd_go = any_gnt & ~sel.we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= 1'b0;
      ram_wr_enb  <= 1'b0;
      ram_wr_addr <= '0;
      ram_data_in <= '0;
      ram_rd_enb  <= 1'b0;
      ram_rd_addr <= '0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
      a_rvalid    <= 1'b0;
      a_rdata     <= '0;
      b_rvalid    <= 1'b0;
      b_rdata     <= '0;
    end else begin
      if (any_gnt) ptr <= a_gnt;
      ram_wr_enb <= any_gnt & sel.we;
      ram_rd_enb <= rd_go;
      if (any_gnt & sel.we) begin
        ram_wr_addr <= sel.addr;
        ram_data_in <= sel.wdata;
      end
      if (rd_go) ram_rd_addr <= sel.addr;
      // Tag follows the read: stage 1 = command on port, stage 2 = RAM data valid.
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_go};
      id_pipe  <= {id_pipe[STAGES-1:1], b_gnt};
      a_rvalid <= vld_pipe[STAGES] & ~id_pipe[STAGES];
      b_rvalid <= vld_pipe[STAGES] &  id_pipe[STAGES];
      if (vld_pipe[STAGES] & ~id_pipe[STAGES]) a_rdata <= ram_data_out;
      if (vld_pipe[STAGES] &  id_pipe[STAGES]) b_rdata <= ram_data_out;
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: behavioural RAM, transaction-level reference model,
// directed scenarios followed by randomized two-client traffic.
module tb_ram_arbiter_2p;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_req, a_we, b_req, b_we;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_wr_enb, ram_rd_enb;
  logic [2:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  // RAM8_8 behaviour: registered write, registered read.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_enb) ram_data_out <= mem[ram_rd_addr];
  end

  typedef struct { bit vld; bit we; bit [2:0] addr; bit [7:0] wdata; } creq_t;
  typedef struct { int due; bit cl; bit [7:0] d; } ret_t;

  creq_t      pa, pb;
  ret_t       rq[$];
  bit [7:0]   shadow [8];
  bit         last_b;
  bit         e_wen, e_ren;
  bit [2:0]   e_wa, e_ra;
  bit [7:0]   e_wd, e_ard, e_brd;
  bit         rnd_a, rnd_b;
  int         cyc, checks, fails;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic creq_t mk(input bit we, input int addr, input int d);
    creq_t r;
    r.vld = 1'b1; r.we = we; r.addr = 3'(addr); r.wdata = 8'(d);
    return r;
  endfunction

  function automatic creq_t rnd_req();
    return mk(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
  endfunction

  function automatic void model_reset();
    pa.vld = 0; pb.vld = 0;
    rq.delete();
    last_b = 1'b1;
    e_wen = 0; e_ren = 0; e_wa = 0; e_ra = 0; e_wd = 0;
    e_ard = 0; e_brd = 0;
  endfunction

  // One clock: drive held requests, check outputs at negedge, advance the model.
  task automatic cycle();
    bit ga, gb, ea, eb;
    creq_t w;
    @(posedge clk); #1;
    if (rnd_a && !pa.vld && $urandom_range(0, 2) != 0) pa = rnd_req();
    if (rnd_b && !pb.vld && $urandom_range(0, 2) != 0) pb = rnd_req();
    a_req = pa.vld;
    a_we    = pa.vld ? pa.we    : 1'($urandom);
    a_addr  = pa.vld ? pa.addr  : 3'($urandom);
    a_wdata = pa.vld ? pa.wdata : 8'($urandom);
    b_req = pb.vld;
    b_we    = pb.vld ? pb.we    : 1'($urandom);
    b_addr  = pb.vld ? pb.addr  : 3'($urandom);
    b_wdata = pb.vld ? pb.wdata : 8'($urandom);
    @(negedge clk);
    ga = pa.vld && (!pb.vld || last_b);
    gb = pb.vld && !ga;
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("ram_wr_enb", ram_wr_enb, e_wen);
    chk("ram_rd_enb", ram_rd_enb, e_ren);
    chk("ram_wr_addr", ram_wr_addr, e_wa);
    chk("ram_data_in", ram_data_in, e_wd);
    chk("ram_rd_addr", ram_rd_addr, e_ra);
    ea = 0; eb = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].cl) begin eb = 1; e_brd = rq[0].d; end
      else          begin ea = 1; e_ard = rq[0].d; end
      rq.delete(0);
    end
    chk("a_rvalid", a_rvalid, ea);
    chk("b_rvalid", b_rvalid, eb);
    chk("a_rdata", a_rdata, e_ard);
    chk("b_rdata", b_rdata, e_brd);
    e_wen = 0; e_ren = 0;
    if (ga || gb) begin
      w = ga ? pa : pb;
      last_b = gb;
      if (w.we) begin
        e_wen = 1; e_wa = w.addr; e_wd = w.wdata;
        shadow[w.addr] = w.wdata;
      end else begin
        e_ren = 1; e_ra = w.addr;
        rq.push_back('{due: cyc + 3, cl: gb, d: shadow[w.addr]});
      end
      if (ga) pa.vld = 0; else pb.vld = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    pa.vld = 0; pb.vld = 0;
    repeat (n) cycle();
  endtask

  // Assert reset mid-cycle, hold for n further edges, release mid-cycle.
  task automatic do_reset(input int n);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
                     ram_wr_enb, ram_wr_addr, ram_data_in, ram_rd_enb, ram_rd_addr}, '0);
    model_reset();
    a_req = 0; b_req = 0;
    repeat (n) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_enb", {ram_wr_enb, ram_rd_enb, a_rvalid, b_rvalid}, '0);
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0;
    rnd_a = 0; rnd_b = 0;
    model_reset();
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    a_addr = 0; b_addr = 1; a_wdata = 8'h5a; b_wdata = 8'ha5;
    #3;
    chk("init_rst_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
                          ram_wr_enb, ram_wr_addr, ram_data_in, ram_rd_enb, ram_rd_addr}, '0);
    @(posedge clk); #2;
    a_req = 0; b_req = 0;
    rst = 1'b1;

    // Both request right after reset: A must win first.
    pa = mk(1, 0, 8'h5a); pb = mk(1, 1, 8'ha5);
    cycle(); cycle();
    for (int i = 2; i < 8; i++) begin pa = mk(1, i, $urandom_range(0, 255)); cycle(); end
    idle(2);

    // A writes 3=11 then reads it back.
    pa = mk(1, 3, 11); cycle();
    pa = mk(0, 3, 0);  cycle();
    idle(4);

    // Contention: A reads 4, B reads 7 continuously.
    pa = mk(1, 4, 22); cycle();
    pb = mk(1, 7, 77); cycle();
    idle(1);
    for (int i = 0; i < 8; i++) begin
      if (!pa.vld) pa = mk(0, 4, 0);
      if (!pb.vld) pb = mk(0, 7, 0);
      cycle();
    end
    idle(4);

    // Write-then-read hazard on addr 7.
    pb = mk(1, 7, 99); cycle();
    pa = mk(0, 7, 0);  cycle();
    idle(5);

    // Reset while a read is in flight.
    pa = mk(0, 2, 0); cycle();
    do_reset(2);
    idle(6);

    // Streaming reads by B.
    for (int i = 0; i < 8; i++) begin pb = mk(1, i, i * 3); cycle(); end
    idle(1);
    for (int i = 0; i < 8; i++) begin pb = mk(0, i, 0); cycle(); end
    idle(5);

    // Random traffic from both clients.
    rnd_a = 1; rnd_b = 1;
    repeat (400) cycle();
    rnd_a = 0; rnd_b = 0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
Two-client arbiter and sequencer for the 8x8 synchronous RAM (RAM8_8). It accepts read/write requests from clients A and B over a req/gnt handshake and picks one winner per cycle by round-robin. It drives the RAM write and read ports with registered one-cycle commands and returns read data to the issuing client with a valid pulse. It sits between datapath clients and the single RAM instance.

Parameters:
ADDR_W, 3, RAM address width (8 words).
DATA_W, 8, RAM data width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset; rst=0 resets.
a_req  in  1  client A request; held until a_gnt.
a_we  in  1  client A: 1=write, 0=read; held with a_req.
a_addr  in  ADDR_W  client A address.
a_wdata  in  DATA_W  client A write data.
a_gnt  out  1  client A request accepted this cycle.
a_rvalid  out  1  client A read data valid, one-cycle pulse.
a_rdata  out  DATA_W  client A read data.
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as client A, for client B.
ram_wr_enb  out  1  to RAM wr_enb.
ram_wr_addr  out  ADDR_W  to RAM wr_addr.
ram_data_in  out  DATA_W  to RAM data_in.
ram_rd_enb  out  1  to RAM rd_enb.
ram_rd_addr  out  ADDR_W  to RAM rd_addr.
ram_data_out  in  DATA_W  from RAM data_out; valid the cycle after the read command.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0. Priority pointer favours A. In-flight read tags cleared.
- Arbitration, cycle t:
  - Only one requester: it wins.
  - Both requesting: the client not granted most recently wins.
  - Pointer updates only on a grant.
  - x_gnt is combinational from req and pointer; high for exactly the winner in cycle t; at most one gnt per cycle.
  - A client must hold req/we/addr/wdata until it sees gnt. It may present a new request in t+1, so back-to-back grants are possible every cycle.
- Command issue, cycle t+1 (registered):
  - Write winner: ram_wr_enb=1 with ram_wr_addr=addr and ram_data_in=wdata for one cycle; ram_rd_enb=0.
  - Read winner: ram_rd_enb=1 with ram_rd_addr=addr for one cycle; ram_wr_enb=0.
  - No grant in t: both enables 0 in t+1. Address and data outputs hold their last issued values.
  - The two enables are never high together.
- Read return:
  - A 2-stage tag pipeline (valid, client id) tracks each read.
  - RAM data is valid in t+2.
  - ram_data_out is captured into the owning client's rdata at the end of t+2.
  - x_rvalid pulses for one cycle in t+3. Read latency is 3 cycles from gnt.
  - x_rdata holds its value until that client's next read return. The other client's rdata/rvalid are unaffected.
- Ordering: commands issue in grant order, so no forwarding is needed. A write granted at t followed by a read of the same address granted at t+1 returns the new data.
- Throughput: one command per cycle. Reads from A and B may be in flight simultaneously; returns stay in grant order.
- Reset mid-operation: in-flight reads are discarded. No rvalid is produced after release for pre-reset grants. A write already on the RAM port during reset assertion is not guaranteed.
- Requests with req=0 ignore we/addr/wdata (X-tolerant).

Test Plan:
- Reset: drive rst=0 between clock edges → all outputs 0 immediately. After release with a_req=b_req=1 → a_gnt first.
- A writes addr3=11 (gnt at t), then A reads addr3 (gnt at t') → ram_wr_enb=1, ram_wr_addr=3, ram_data_in=11 in t+1; ram_rd_enb=1, ram_rd_addr=3 in t'+1; a_rvalid=1, a_rdata=11 in t'+3; b_rvalid stays 0.
- Contention: preload addr4=22, addr7=77; A reads 4 and B reads 7, both requesting continuously → grants alternate A,B,A,B; rvalid pulses alternate with a_rdata=22 and b_rdata=77, 3 cycles after each gnt.
- Write-then-read hazard: B writes addr7=99 granted at t, A reads addr7 granted at t+1 → a_rvalid at t+4 with a_rdata=99.
- Reset mid-read: A read granted at t, rst=0 during t+1, released at t+3 → a_rvalid never asserts; ram enables 0 after release.
- Streaming: B alone reads addrs 0..7 on 8 consecutive cycles (RAM preloaded with addr*3) → b_gnt high 8 cycles; 8 consecutive b_rvalid pulses carrying 0,3,6,...,21 in order.
